// File: rtl/output_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | output_drain: streams a filled output buffer region out over valid/ready.   |
// | Revision 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module output_drain #(
    parameter int DIMDATA_SIZE = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                    w_clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   initial_address,
    input  logic [DIMDATA_SIZE-1:0] output_featuremapsize,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    output logic [ADDR_WIDTH-1:0]   r_address,
    output logic                    read_enable,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DIMDATA_SIZE-1:0] size_q, size_d;
    logic [DIMDATA_SIZE-1:0] issued_q, issued_d, issued_inc;
    logic [DIMDATA_SIZE-1:0] sent_q, sent_d, sent_inc;
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic                    inflight_q;
    logic [1:0]              count_q;
    logic [1:0]              occ;
    logic                    pop, bypass, fifo_pop, push;

    // The word returning from the buffer counts as a FIFO entry on its return
    // cycle, so it is presented directly from rd_data while the storage is empty.
    assign occ       = count_q + {1'b0, inflight_q};
    assign out_valid = (count_q != 2'd0) | inflight_q;
    assign pop       = out_valid & out_ready;
    assign bypass    = pop & (count_q == 2'd0);
    assign fifo_pop  = pop & (count_q != 2'd0);
    assign push      = inflight_q & ~bypass;

    always_comb begin
        out_data = '0;
        if (count_q != 2'd0) begin
            out_data = fifo_q[rd_ptr_q];
        end else if (inflight_q) begin
            out_data = rd_data;
        end
    end

    assign read_enable = (state_q == S_RUN) && (issued_q < size_q) &&
                         ((occ - {1'b0, pop}) < 2'd2);
    assign r_address   = read_enable ? (base_q + issued_q[ADDR_WIDTH-1:0]) : addr_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done        = (state_q == S_DONE);

    assign issued_inc = issued_q + {{(DIMDATA_SIZE-1){1'b0}}, 1'b1};
    assign sent_inc   = sent_q + {{(DIMDATA_SIZE-1){1'b0}}, pop};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        size_d   = size_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    base_d   = initial_address;
                    size_d   = output_featuremapsize;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (output_featuremapsize == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                sent_d = sent_inc;
                if (read_enable) begin
                    issued_d = issued_inc;
                    if (issued_inc == size_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                sent_d = sent_inc;
                if (sent_inc == size_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            addr_q     <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            size_q     <= size_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            addr_q     <= r_address;
            inflight_q <= read_enable;
            if (push) begin
                fifo_q[wr_ptr_q] <= rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_drain.sv
`default_nettype none
// tb_output_drain: randomized drains checked against a queue-based expectation model.
module tb_output_drain;

    logic        w_clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [13:0] initial_address = '0;
    logic [15:0] output_featuremapsize = '0;
    logic [15:0] rd_data = '0;
    logic [13:0] r_address;
    logic        read_enable;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    output_drain dut (
        .w_clk                 (w_clk),
        .reset                 (reset),
        .start                 (start),
        .initial_address       (initial_address),
        .output_featuremapsize (output_featuremapsize),
        .rd_data               (rd_data),
        .r_address             (r_address),
        .read_enable           (read_enable),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 w_clk = ~w_clk;

    logic [15:0] mem [0:16383];

    // Buffer model: registered read with one cycle of latency.
    always @(posedge w_clk) begin
        if (read_enable) rd_data <= mem[r_address];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int exp_addr[$];
    int exp_data[$];
    int drain_size, n_reads, n_xfers, pend;
    int first_valid, last_xfer;
    bit prev_valid, prev_ready;
    logic [15:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        int p;
        p = (out_valid && out_ready) ? 1 : 0;
        if (read_enable) begin
            chk("pending_lt2", ((pend - p) < 2) ? 32'd1 : 32'd0, 32'd1);
            if (exp_addr.size() == 0) chk("extra_read", n_reads + 1, drain_size);
            else chk("r_address", {18'd0, r_address}, exp_addr.pop_front());
            n_reads++;
        end
        if (prev_valid && !prev_ready) begin
            chk("valid_hold", {31'd0, out_valid}, 32'd1);
            chk("data_hold", {16'd0, out_data}, {16'd0, prev_data});
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (p == 1) begin
            if (exp_data.size() == 0) chk("extra_xfer", n_xfers + 1, drain_size);
            else chk("out_data", {16'd0, out_data}, exp_data.pop_front());
            n_xfers++;
            last_xfer = cyc;
        end
        if (read_enable) pend++;
        pend = pend - p;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
    endtask

    task automatic tick();
        @(negedge w_clk);
        check_cycle();
        @(posedge w_clk);
        cyc++;
        #1;
    endtask

    task automatic set_ready(input int mode);
        out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, {18'd0, r_address}, 32'd0);
        chk({tag, "_re"}, {31'd0, read_enable}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"}, {16'd0, out_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // mode 1: out_ready held high; mode 2: out_ready random each cycle.
    task automatic drain(input int base, input int size, input int mode,
                         input int ign_at, input int abort_after);
        int sc;
        int k;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < size; i++) begin
            exp_addr.push_back((base + i) % 16384);
            exp_data.push_back(int'(mem[(base + i) % 16384]));
        end
        drain_size  = size;
        n_reads     = 0;
        n_xfers     = 0;
        first_valid = -1;
        last_xfer   = -1;
        initial_address       = 14'(base);
        output_featuremapsize = 16'(size);
        start = 1'b1;
        set_ready(mode);
        sc = cyc;
        tick();
        start = 1'b0;
        chk("done_after_start", {31'd0, done}, (size == 0) ? 32'd1 : 32'd0);
        chk("busy_after_start", {31'd0, busy}, (size == 0) ? 32'd0 : 32'd1);
        if (size == 0) begin
            for (int i = 0; i < 3; i++) begin
                set_ready(mode);
                tick();
                chk("zero_busy", {31'd0, busy}, 32'd0);
                chk("zero_done", {31'd0, done}, 32'd1);
            end
            chk("zero_reads", n_reads, 0);
            return;
        end
        k = 0;
        while (n_xfers < size && k < 400) begin
            if (abort_after > 0 && n_xfers == abort_after) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_addr.delete();
                exp_data.delete();
                pend = 0;
                prev_valid = 1'b0;
                @(negedge w_clk);
                reset = 1'b1;
                @(posedge w_clk);
                cyc++;
                #1;
                check_reset_outputs("post_abort");
                return;
            end
            set_ready(mode);
            if (k == ign_at) begin
                start = 1'b1;
                initial_address = 14'd50;
                output_featuremapsize = 16'd9;
            end
            tick();
            start = 1'b0;
            k++;
        end
        chk("xfer_count", n_xfers, size);
        chk("read_count", n_reads, size);
        chk("done_final", {31'd0, done}, 32'd1);
        chk("busy_final", {31'd0, busy}, 32'd0);
        chk("re_final", {31'd0, read_enable}, 32'd0);
        chk("first_valid_lat", first_valid - sc, 2);
        if (mode == 1) chk("last_xfer_lat", last_xfer - sc, size + 1);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        pend = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data = '0;
        repeat (3) @(posedge w_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge w_clk);
        reset = 1'b1;
        @(posedge w_clk);
        #1;

        drain(100, 8, 1, -1, 0);
        drain(100, 8, 2, -1, 0);
        drain(16382, 4, 2, -1, 0);
        drain(0, 0, 1, -1, 0);
        drain(0, 6, 1, 2, 0);
        drain(50, 2, 1, -1, 0);
        drain(200, 10, 1, -1, 3);
        drain(300, 10, 2, -1, 0);
        for (int t = 0; t < 6; t++) begin
            drain(int'($urandom_range(0, 16383)), int'($urandom_range(1, 12)), 2, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_drain.md
Name: output_drain

Overview:
- Read-side counterpart of the output buffer fill controller.
- Once a filled output feature map sits in the on-chip output buffer, this block generates read addresses and read enables for the buffer.
- It absorbs the buffer's 1-cycle read latency and streams the words out over a valid/ready interface to the next stage (host DMA or next-layer loader).
- It signals done when the whole map has been handed off.

Parameters:
- dimdata_size, 16, width of the feature-map size input.
- data_width, 16, width of one buffer word.
- addr_width, 14, buffer address width.

Ports:
- w_clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  1-cycle pulse that begins a drain; sampled only in IDLE or DONE.
- initial_address  input  addr_width  first buffer address; latched on start.
- output_featuremapsize  input  dimdata_size  number of words to drain; latched on start.
- rd_data  input  data_width  buffer read data, valid 1 cycle after read_enable.
- r_address  output  addr_width  buffer read address.
- read_enable  output  1  buffer read strobe.
- out_data  output  data_width  streamed word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- busy  output  1  high in RUN and FLUSH.
- done  output  1  level, high in DONE.

Behaviour:
- Reset (async, reset=0):
  - Outputs: r_address=0, read_enable=0, out_valid=0, out_data=0, busy=0, done=0.
  - State IDLE; internal counters and FIFO cleared.
  - Reset mid-drain aborts immediately. No further reads are issued and buffered words are discarded.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE with start=1:
  - Latch base=initial_address and size=output_featuremapsize.
  - Clear issued and sent counters; done drops the next cycle.
  - size=0: go directly to DONE with no reads and done=1 the next cycle.
  - Otherwise go to RUN.
- Start in RUN or FLUSH is ignored; latched values are unchanged.
- RUN, read issue:
  - Internal 2-entry output FIFO.
  - Issue a read (read_enable=1, r_address=base+issued, mod 2^addr_width) when issued<size and (fifo_count + reads_in_flight − pops_this_cycle) < 2.
  - reads_in_flight is 0 or 1 (latency 1).
  - Sustains 1 word/cycle when out_ready is held high.
- Read return: the word captured from rd_data on the cycle after read_enable is pushed into the FIFO. Push and pop in the same cycle are legal.
- Address behaviour:
  - r_address holds its last value when read_enable=0.
  - Address wraps from 2^addr_width−1 to 0.
  - issued and sent counters are dimdata_size bits wide.
- Output side:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Once asserted, out_valid and out_data stay stable until out_ready=1 (no retraction).
  - Transfer happens on out_valid & out_ready; sent increments on each transfer.
- RUN→FLUSH when issued reaches size after the final read issue.
- FLUSH→DONE when sent reaches size. done=1 from the cycle after the last transfer.
- DONE:
  - done, busy=0, and read_enable=0 hold until the next start.
- Latency: first out_valid 2 cycles after the start cycle (start at T, read at T+1, out_valid at T+2).
- Overflow: words are never dropped and the FIFO never overflows, regardless of out_ready pattern.

Test Plan:
- Reset, then start with initial_address=100 and size=8; out_ready held 1.
  - Reads at addresses 100..107 on consecutive cycles.
  - out_valid from start+2 for 8 consecutive cycles; data matches the buffer model.
  - done=1 one cycle after the 8th transfer.
- Same drain with out_ready toggling 1,0,0,1,... pseudo-randomly.
  - All 8 words delivered in order with none duplicated.
  - out_data stable while out_valid=1 and out_ready=0.
  - read_enable never issued with 2 entries pending.
- initial_address=16382, size=4 -> addresses 16382, 16383, 0, 1 and 4 correct words.
- size=0 start -> no read_enable; done=1 the cycle after start; busy never high.
- Second start pulse mid-RUN (size=6, base=0; ignored start carries base=50) -> only addresses 0..5 read. A new start in DONE with base=50, size=2 reads 50 and 51; done drops then re-asserts.
- reset asserted after 3 transfers of a 10-word drain.
  - All outputs 0 asynchronously and state returns to IDLE.
  - A following start drains the full new map correctly.
